// File: rtl/alu_mdu_seq_pkg.sv
// rtl/alu_mdu_seq_pkg.sv - op codes, FSM encoding and op-class helpers for alu_mdu_seq
package alu_mdu_seq_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
    localparam logic [OP_W-1:0] OP_AND   = 5'd2;
    localparam logic [OP_W-1:0] OP_OR    = 5'd3;
    localparam logic [OP_W-1:0] OP_NOR   = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 5'd5;
    localparam logic [OP_W-1:0] OP_SLL   = 5'd6;
    localparam logic [OP_W-1:0] OP_SRL   = 5'd7;
    localparam logic [OP_W-1:0] OP_SRA   = 5'd8;
    localparam logic [OP_W-1:0] OP_SLT   = 5'd9;
    localparam logic [OP_W-1:0] OP_SLTU  = 5'd10;
    localparam logic [OP_W-1:0] OP_LUI   = 5'd11;
    localparam logic [OP_W-1:0] OP_MULT  = 5'd16;
    localparam logic [OP_W-1:0] OP_MULTU = 5'd17;
    localparam logic [OP_W-1:0] OP_DIV   = 5'd18;
    localparam logic [OP_W-1:0] OP_DIVU  = 5'd19;
    localparam logic [OP_W-1:0] OP_MFHI  = 5'd20;
    localparam logic [OP_W-1:0] OP_MFLO  = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// rtl/alu_mdu_seq_if.sv - operation request / result bundle between ID/EX latches and the ALU
// master (control/datapath side): drives op_valid, alu_op, a, b, shamt
// slave  (alu_mdu_seq): drives op_ready, res_valid, result, zero, overflow, div_by_zero, hi, lo
interface alu_mdu_seq_if
    import alu_mdu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               op_valid;
    logic               op_ready;
    logic [OP_W-1:0]    alu_op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               res_valid;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               overflow;
    logic               div_by_zero;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (
        output op_valid, alu_op, a, b, shamt,
        input  op_ready, res_valid, result, zero, overflow, div_by_zero, hi, lo
    );

    modport slave (
        input  op_valid, alu_op, a, b, shamt,
        output op_ready, res_valid, result, zero, overflow, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu_mdu_seq_mdu_iter.sv
// rtl/alu_mdu_seq_mdu_iter.sv - iterative 1-bit/cycle shift-add multiplier and restoring divider
// in : clk, reset (async, active-low), start (load operands), is_signed, is_div, a, b
// out: done (final iteration is being taken this cycle), hi/lo (sign-corrected result of that iteration)
module mdu_iter
    import alu_mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;         // quotient/product must be negated
    logic             neg_rem_q, neg_rem_d; // remainder takes the dividend sign
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;         // product upper half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;           // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] mb_q, mb_d;           // divisor / multiplicand magnitude

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] ma, mb;
    logic [WIDTH:0]   r_sh, trial, sum, acc_n;
    logic [WIDTH-1:0] lo_n;
    logic [2*WIDTH-1:0] prod, prod_c;

    // Operate on magnitudes; MIN maps onto 2^(WIDTH-1), which still fits unsigned.
    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign ma    = a_neg ? (~a + 1'b1) : a;
    assign mb    = b_neg ? (~b + 1'b1) : b;

    // One iteration. The partial remainder stays below the divisor, and the
    // product upper half never carries past WIDTH bits, so acc_q[WIDTH] is
    // only a transient borrow/carry position.
    always_comb begin
        r_sh  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial = r_sh - {1'b0, mb_q};
        sum   = acc_q + (lo_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
        if (div_q) begin
            if (!trial[WIDTH]) begin
                acc_n = trial;
                lo_n  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = r_sh;
                lo_n  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = {1'b0, sum[WIDTH:1]};
            lo_n  = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign post-correction of the value produced by this iteration.
    assign prod   = {acc_n[WIDTH-1:0], lo_n};
    assign prod_c = neg_q ? (~prod + 1'b1) : prod;

    always_comb begin
        if (div_q) begin
            lo = neg_q ? (~lo_n + 1'b1) : lo_n;
            hi = neg_rem_q ? (~acc_n[WIDTH-1:0] + 1'b1) : acc_n[WIDTH-1:0];
        end else begin
            hi = prod_c[2*WIDTH-1:WIDTH];
            lo = prod_c[WIDTH-1:0];
        end
    end

    assign done = busy_q && (cnt_q == LAST);

    always_comb begin
        busy_d    = busy_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        mb_d      = mb_q;
        if (start) begin
            busy_d    = 1'b1;
            div_d     = is_div;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            acc_d     = '0;
            lo_d      = is_div ? ma : mb;
            mb_d      = is_div ? mb : ma;
        end else if (busy_q) begin
            acc_d = acc_n;
            lo_d  = lo_n;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            mb_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            mb_q      <= mb_d;
        end
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - multicycle MIPS ALU with iterative MUL/DIV, HI/LO and registered result
// in : clk, reset (async, active-low), bus.slave (op_valid/alu_op/a/b/shamt request)
// out: bus.slave (op_ready, res_valid pulse, result, zero, overflow, div_by_zero, hi, lo)
module alu_mdu_seq
    import alu_mdu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       reset,
    alu_mdu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               accept, div_zero, mdu_start, mdu_done;
    logic [WIDTH-1:0]   mdu_hi, mdu_lo;
    logic [WIDTH-1:0]   alu_res, sum, diff;
    logic               alu_ovf;
    logic [SHAMT_W-1:0] shamt;

    assign shamt     = bus.shamt;
    assign accept    = bus.op_valid && (state_q == ST_IDLE);
    assign div_zero  = is_div_op(bus.alu_op) && (bus.b == '0);
    // A zero divisor is answered directly, without entering BUSY.
    assign mdu_start = accept && is_muldiv(bus.alu_op) && !div_zero;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk       (clk),
        .reset     (reset),
        .start     (mdu_start),
        .is_signed (is_signed_muldiv(bus.alu_op)),
        .is_div    (is_div_op(bus.alu_op)),
        .a         (bus.a),
        .b         (bus.b),
        .done      (mdu_done),
        .hi        (mdu_hi),
        .lo        (mdu_lo)
    );

    // Single-cycle datapath, evaluated on the request inputs in the accept cycle.
    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SLL:  alu_res = bus.b << shamt;
            OP_SRL:  alu_res = bus.b >> shamt;
            OP_SRA:  alu_res = $signed(bus.b) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_LUI:  alu_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_DIV,
            OP_DIVU: alu_res = '1;    // only reached with a zero divisor
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = mdu_start ? ST_BUSY : ST_RESP;
            ST_BUSY: if (mdu_done) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.op_ready  = (state_q == ST_IDLE);
        bus.res_valid = (state_q == ST_RESP);
    end

    // Result, flags and HI/LO are loaded on the edge that enters RESP.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (accept && !mdu_start) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            dbz_d    = div_zero;
            if (div_zero) begin
                hi_d = bus.a;
                lo_d = '1;
            end
        end else if ((state_q == ST_BUSY) && mdu_done) begin
            result_d = mdu_lo;
            zero_d   = (mdu_lo == '0);
            ovf_d    = 1'b0;
            dbz_d    = 1'b0;
            hi_d     = mdu_hi;
            lo_d     = mdu_lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - directed scoreboard bench for alu_mdu_seq
module tb_alu_mdu_seq;
    import alu_mdu_seq_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_seq_if #(.WIDTH(32)) bus ();

    alu_mdu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: plain wide arithmetic, HI/LO kept in mhi/mlo.
    function automatic exp_t model(input string tag, input logic [4:0] op,
                                   input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        longint      sa, sbv, s, q, r;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        e.tag = tag;
        e.res = '0;
        e.ov  = 1'b0;
        e.dz  = 1'b0;
        e.lat = 1;
        case (op)
            OP_ADD:  begin s = sa + sbv; e.res = a + b; e.ov = (s > SMAX) || (s < SMIN); end
            OP_SUB:  begin s = sa - sbv; e.res = a - b; e.ov = (s > SMAX) || (s < SMIN); end
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_NOR:  e.res = ~(a | b);
            OP_XOR:  e.res = a ^ b;
            OP_SLL:  e.res = b << sh;
            OP_SRL:  e.res = b >> sh;
            OP_SRA:  e.res = $signed(b) >>> sh;
            OP_SLT:  e.res = (sa < sbv) ? 32'd1 : 32'd0;
            OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
            OP_LUI:  e.res = {b[15:0], 16'h0000};
            OP_MULT: begin p = 64'(sa * sbv); {mhi, mlo} = p; e.res = mlo; e.lat = 33; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = p; e.res = mlo; e.lat = 33; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    e.dz = 1'b1; mlo = '1; mhi = a;
                end else if (op == OP_DIV) begin
                    q = sa / sbv; r = sa % sbv;
                    p = 64'(q); mlo = p[31:0];
                    p = 64'(r); mhi = p[31:0];
                    e.lat = 33;
                end else begin
                    mlo = a / b; mhi = a % b; e.lat = 33;
                end
                e.res = mlo;
            end
            OP_MFHI: e.res = mhi;
            OP_MFLO: e.res = mlo;
            default: e.res = '0;
        endcase
        e.z  = (e.res == 0);
        e.hi = mhi;
        e.lo = mlo;
        return e;
    endfunction

    // Called right after the accepting edge; pops the scoreboard at res_valid.
    task automatic wait_result();
        exp_t e;
        int   lat;
        bit   seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({e.tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({e.tag, "_lat"},    lat,             e.lat);
            chk({e.tag, "_result"}, bus.result,      e.res);
            chk({e.tag, "_zero"},   bus.zero,        e.z);
            chk({e.tag, "_ovf"},    bus.overflow,    e.ov);
            chk({e.tag, "_dbz"},    bus.div_by_zero, e.dz);
            chk({e.tag, "_hi"},     bus.hi,          e.hi);
            chk({e.tag, "_lo"},     bus.lo,          e.lo);
            @(negedge clk);
            chk({e.tag, "_pulse"},  bus.res_valid,   1'b0);
        end
    endtask

    task automatic issue(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        chk({tag, "_ready"}, bus.op_ready, 1'b1);
        bus.op_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = sh;
        sb.push_back(model(tag, op, a, b, sh));
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        wait_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   busy;
        int   pulses;
        bit   saw_rv;

        bus.op_valid = 1'b0;
        bus.alu_op   = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.shamt    = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready",  bus.op_ready,    1'b1);
        chk("rst_rvalid", bus.res_valid,   1'b0);
        chk("rst_result", bus.result,      32'd0);
        chk("rst_zero",   bus.zero,        1'b1);
        chk("rst_ovf",    bus.overflow,    1'b0);
        chk("rst_dbz",    bus.div_by_zero, 1'b0);
        chk("rst_hi",     bus.hi,          32'd0);
        chk("rst_lo",     bus.lo,          32'd0);
        rst_n = 1'b1;

        issue("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        chk("add_ovf_spec", bus.result, 32'h8000_0000);
        issue("sub_zero", OP_SUB, 32'd5, 32'd5, 5'd0);
        issue("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h1, 5'd0);
        issue("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        issue("or",  OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        issue("nor", OP_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        issue("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        issue("sll", OP_SLL, 32'h0, 32'h0000_0003, 5'd31);
        issue("srl", OP_SRL, 32'h0, 32'hF000_0000, 5'd4);
        chk("srl_spec", bus.result, 32'h0F00_0000);
        issue("sra", OP_SRA, 32'h0, 32'hF000_0000, 5'd4);
        chk("sra_spec", bus.result, 32'hFF00_0000);
        issue("slt",  OP_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0);
        issue("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0);
        issue("lui",  OP_LUI,  32'h0, 32'h0000_1234, 5'd0);
        chk("lui_spec", bus.result, 32'h1234_0000);
        issue("bad_op", 5'd12, 32'd5, 32'd6, 5'd0);

        issue("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0);
        chk("mult_hi_spec", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo_spec", bus.lo, 32'hFFFF_FFFA);
        issue("mfhi", OP_MFHI, 32'd0, 32'd0, 5'd0);
        issue("mflo", OP_MFLO, 32'd0, 32'd0, 5'd0);
        issue("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5'd0);
        chk("multu_hi_spec", bus.hi, 32'h0000_0002);
        issue("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
        chk("div_lo_spec", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi_spec", bus.hi, 32'hFFFF_FFFF);
        issue("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        chk("div_min_spec", bus.lo, 32'h8000_0000);
        issue("divu_zero", OP_DIVU, 32'hDEAD_BEEF, 32'd0, 5'd0);
        issue("mfhi_dz", OP_MFHI, 32'd0, 32'd0, 5'd0);
        issue("divu", OP_DIVU, 32'd100, 32'd7, 5'd0);
        issue("div_nb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd0);
        issue("mult_rnd", OP_MULT, $urandom, $urandom, 5'd0);
        issue("divu_rnd", OP_DIVU, $urandom, $urandom_range(1, 65535), 5'd0);

        // op_valid held high through a MULT, then an ADD follows once ready returns
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.alu_op   = OP_MULT;
        bus.a        = 32'h0001_2345;
        bus.b        = 32'hFFFF_FF00;
        bus.shamt    = '0;
        sb.push_back(model("held_mult", OP_MULT, 32'h0001_2345, 32'hFFFF_FF00, 5'd0));
        busy   = 0;
        pulses = 0;
        @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.op_ready) break;
            busy++;
            if (bus.res_valid) begin
                pulses++;
                e = sb.pop_front();
                chk("held_mult_result", bus.result, e.res);
                chk("held_mult_hi",     bus.hi,     e.hi);
                bus.alu_op = OP_ADD;
                bus.a      = 32'd3;
                bus.b      = 32'd4;
                sb.push_back(model("held_add", OP_ADD, 32'd3, 32'd4, 5'd0));
            end
        end
        chk("held_busy_cycles", busy, 33);
        chk("held_pulses", pulses, 1);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        wait_result();

        // reset during BUSY aborts the MULT
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.alu_op   = OP_MULT;
        bus.a        = 32'd5;
        bus.b        = 32'd7;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready",  bus.op_ready,    1'b1);
        chk("abort_rvalid", bus.res_valid,   1'b0);
        chk("abort_result", bus.result,      32'd0);
        chk("abort_zero",   bus.zero,        1'b1);
        chk("abort_ovf",    bus.overflow,    1'b0);
        chk("abort_dbz",    bus.div_by_zero, 1'b0);
        chk("abort_hi",     bus.hi,          32'd0);
        chk("abort_lo",     bus.lo,          32'd0);
        mhi    = '0;
        mlo    = '0;
        saw_rv = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.res_valid) saw_rv = 1'b1;
        end
        chk("abort_no_rvalid", saw_rv, 1'b0);
        issue("post_add",  OP_ADD,  32'd10, 32'd20, 5'd0);
        issue("post_mfhi", OP_MFHI, 32'd0,  32'd0,  5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
